// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) byte helpers for the
// inverse-round datapath.
package aes_pkg;

    localparam int NR      = 10;
    localparam int STATE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Inverse S-box, entry 0 in the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TAB[b];
    endfunction

    // Multiply by x (0x02) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; used with 9, 11, 13 and 14.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = 8'h00;
        if (k[0]) r = r ^ b;
        if (k[1]) r = r ^ x2;
        if (k[2]) r = r ^ x4;
        if (k[3]) r = r ^ x8;
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// Inverse MixColumns over all four columns, purely combinational.
module aes_inv_mixcolumns
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] in_state,
    output logic [STATE_W-1:0] out_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;

        assign a0 = in_state[STATE_W-1-32*c    -: 8];
        assign a1 = in_state[STATE_W-1-32*c-8  -: 8];
        assign a2 = in_state[STATE_W-1-32*c-16 -: 8];
        assign a3 = in_state[STATE_W-1-32*c-24 -: 8];

        assign out_state[STATE_W-1-32*c    -: 8] =
            gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
        assign out_state[STATE_W-1-32*c-8  -: 8] =
            gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13);
        assign out_state[STATE_W-1-32*c-16 -: 8] =
            gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11);
        assign out_state[STATE_W-1-32*c-24 -: 8] =
            gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14);
    end

endmodule

// File: rtl/inv_shiftrows.sv
// Inverse ShiftRows: row r of the column-major state rotates right by r bytes.
module inv_shiftrows
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] in_state,
    output logic [STATE_W-1:0] out_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign out_state[STATE_W-1-8*(r+4*c) -: 8] =
                in_state[STATE_W-1-8*(r+4*((c+4-r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128 decryption engine: one inverse round per clock, round
// keys fetched by index from an external store, plaintext held until taken.
module aes_inv_round_engine
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic [3:0]         rk_idx,
    input  logic [STATE_W-1:0] rk_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    fsm_state_t         fsm_q;
    fsm_state_t         fsm_next;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_next;
    logic [3:0]         ctr_q;
    logic [3:0]         ctr_next;
    logic               out_valid_q;
    logic               out_valid_next;
    logic [STATE_W-1:0] out_data_q;
    logic [STATE_W-1:0] out_data_next;

    logic [STATE_W-1:0] sr_out;
    logic [STATE_W-1:0] sb_out;
    logic [STATE_W-1:0] ark_out;
    logic [STATE_W-1:0] mc_out;

    inv_shiftrows u_inv_shiftrows (
        .in_state  (state_q),
        .out_state (sr_out)
    );

    for (genvar i = 0; i < 16; i++) begin : g_inv_sub
        assign sb_out[STATE_W-1-8*i -: 8] = inv_sbox(sr_out[STATE_W-1-8*i -: 8]);
    end

    // The final round output is the key-added value before InvMixColumns.
    assign ark_out = sb_out ^ rk_data;

    aes_inv_mixcolumns u_inv_mixcolumns (
        .in_state  (ark_out),
        .out_state (mc_out)
    );

    // Next-state, round-key index and handshake decode.
    always_comb begin
        fsm_next       = fsm_q;
        state_next     = state_q;
        ctr_next       = ctr_q;
        out_valid_next = out_valid_q;
        out_data_next  = out_data_q;
        rk_idx         = 4'd0;
        in_ready       = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                rk_idx   = 4'(NR);
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = in_data ^ rk_data;
                    ctr_next   = 4'(NR - 1);
                    fsm_next   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_idx     = ctr_q;
                state_next = mc_out;
                if (ctr_q <= 4'd1) begin
                    fsm_next = ST_FINAL;
                end else begin
                    ctr_next = ctr_q - 4'd1;
                end
            end
            ST_FINAL: begin
                rk_idx         = 4'd0;
                state_next     = ark_out;
                out_data_next  = ark_out;
                out_valid_next = 1'b1;
                fsm_next       = ST_DONE;
            end
            ST_DONE: begin
                rk_idx = 4'd0;
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    fsm_next       = ST_IDLE;
                end
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
    end

    // State register, round counter and output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            ctr_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fsm_q       <= fsm_next;
            state_q     <= state_next;
            ctr_q       <= ctr_next;
            out_valid_q <= out_valid_next;
            out_data_q  <= out_data_next;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (fsm_q != ST_IDLE);

endmodule
